usbdev_aon_resume_gen: RTL and testbench
========================================

// Module: usbdev_aon_resume_gen
// PURPOSE
// - AON-domain remote-wakeup transmitter. It is the device-driven counterpart of the AON wake detector.
// - While the link is suspended and the IP has armed remote wakeup, it waits for the bus to stay idle (J) long enough.
// - It then drives K resume signalling on the pins for a fixed period and hands the line back to the host.
// - Sits beside the AON wake detector; its pin outputs are muxed onto the USB transceiver drive path.
// PARAMETERS
// - IdleCycles    1000  consecutive synchronised J cycles required before driving K (5 ms at 200 kHz)
// - ResumeCycles  400   cycles K is driven (2 ms; legal range 1-15 ms)
// - TimeoutCycles 4000  max cycles spent waiting for idle; used only with USBDEV_AON_RESUME_TIMEOUT_EN
// - CntW          13    counter width; must hold max(IdleCycles, ResumeCycles, TimeoutCycles)
// PORTS
// - clk_aon_i        in   1  AON clock, ~200 kHz
// - rst_aon_ni       in   1  reset rst_aon_ni, asynchronous, active-low
// - usb_dp_i         in   1  D+ pin level, asynchronous
// - usb_dn_i         in   1  D- pin level, asynchronous
// - suspended_aon_i  in   1  AON wake detector active (link suspended), AON domain
// - wake_en_aon_i    in   1  host has enabled remote wakeup (SET_FEATURE), AON domain
// - wake_req_aon_i   in   1  single-cycle request to send remote wakeup, AON domain
// - usb_oe_o         out  1  transceiver output enable; 1 = this block drives the pins
// - usb_dp_o         out  1  D+ drive value
// - usb_dn_o         out  1  D- drive value
// - busy_o           out  1  request accepted and not yet finished
// - done_o           out  1  one-cycle pulse: K signalling completed
// - abort_o          out  1  one-cycle pulse: request dropped without completing
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0; no pending request.
// - usb_dp_i/usb_dn_i pass through a 2-flop synchroniser (prim_flop_2sync). J = (dp_s==1 && dn_s==0). SE0 and K are both non-J.
// - FSM: IDLE -> WAIT_IDLE -> DRIVE_K -> RELEASE -> IDLE.
// - IDLE: on wake_req_aon_i && wake_en_aon_i && suspended_aon_i, move to WAIT_IDLE and clear cnt. busy_o=1 from the next cycle.
//   - A request that fails this qualification is ignored; no abort_o.
// - WAIT_IDLE:
//   - cnt increments on each J cycle and clears to 0 on any non-J cycle.
//   - When cnt==IdleCycles-1 and the bus is still J, move to DRIVE_K and clear cnt.
//   - If suspended_aon_i or wake_en_aon_i drops: abort_o pulse, return to IDLE.
//     - This covers host-initiated resume/reset, which ends suspend.
// - DRIVE_K:
//   - Registered outputs usb_oe_o=1, usb_dp_o=0, usb_dn_o=1, asserted the cycle after entry.
//   - cnt increments each cycle. At cnt==ResumeCycles-1, move to RELEASE.
//   - suspended_aon_i is ignored; suspend normally drops as a result of our own K.
// - RELEASE (1 cycle):
//   - usb_oe_o=0, usb_dp_o=0, usb_dn_o=0.
//   - done_o pulses. busy_o falls, then IDLE.
// - Length of the drive: usb_oe_o is high for exactly ResumeCycles cycles.
// - Exit pulses: done_o and abort_o are mutually exclusive and each last exactly 1 cycle. busy_o deasserts in the same cycle as the pulse.
// - wake_req_aon_i while busy_o=1 is ignored; it is not queued.
// - wake_en_aon_i dropping during DRIVE_K does not truncate K; the full period is always sent.
// - Async reset mid-DRIVE_K: usb_oe_o deasserts immediately (flops are reset), with no done_o or abort_o pulse.
// - Counters saturate and never wrap. The RTL includes an assertion that CntW is large enough for every parameter.
// CONFIGURATION
// - USBDEV_AON_RESUME_TIMEOUT_EN defined:
//   - A separate timer counts every cycle spent in WAIT_IDLE.
//   - Reaching TimeoutCycles gives an abort_o pulse and a return to IDLE.
// - USBDEV_AON_RESUME_TIMEOUT_EN undefined:
//   - No timer; WAIT_IDLE persists until idle is reached or the qualifiers drop.
// TESTING
// - Bus J, suspended=1, en=1, req pulse at cycle 0 -> busy_o=1 at cycle 1; usb_oe_o=1 with dp=0/dn=1 for exactly 400 cycles, starting ~1002 cycles later; done_o single pulse; busy_o=0.
// - Same, but a 3-cycle SE0 glitch at cycle 600 -> idle count restarts after the glitch; K drive starts ~1000 cycles after it ends.
// - req with en=0 or suspended=0 -> busy_o, usb_oe_o, done_o and abort_o all stay 0.
// - suspended drops at cycle 500 of WAIT_IDLE -> abort_o pulse, busy_o=0, usb_oe_o never asserted.
// - rst_aon_ni asserted at cycle 100 of DRIVE_K -> usb_oe_o=0 immediately; no done_o; a subsequent req works normally.
// - USBDEV_AON_RESUME_TIMEOUT_EN defined, bus held in K -> abort_o pulse after 4000 cycles in WAIT_IDLE; undefined -> stays busy.

Source files
------------

// File: rtl/usbdev_aon_resume_gen.sv
// AON remote-wakeup generator: waits for a long bus idle, drives K resume, then releases the line.
// Optional wait-for-idle timeout is enabled by defining USBDEV_AON_RESUME_TIMEOUT_EN.

module usbdev_aon_resume_gen_chk #(
  parameter int IdleCycles    = 1000,
  parameter int ResumeCycles  = 400,
  parameter int TimeoutCycles = 4000,
  parameter int CntW          = 13
) (
  input logic clk_aon_i
);
  localparam longint MaxCnt = (64'sd1 <<< CntW) - 64'sd1;
  localparam bit CntWOk = (IdleCycles >= 1) && (ResumeCycles >= 1) && (TimeoutCycles >= 1) &&
                          (IdleCycles <= MaxCnt) && (ResumeCycles <= MaxCnt) &&
                          (TimeoutCycles <= MaxCnt);

  // Counter width must hold every configured interval.
  always_ff @(posedge clk_aon_i) begin
    assert (CntWOk) else $error("usbdev_aon_resume_gen: CntW too small for configured cycle counts");
  end
endmodule

module usbdev_aon_resume_gen #(
  parameter int IdleCycles    = 1000,
  parameter int ResumeCycles  = 400,
  parameter int TimeoutCycles = 4000,
  parameter int CntW          = 13
) (
  input  logic clk_aon_i,
  input  logic rst_aon_ni,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  input  logic suspended_aon_i,
  input  logic wake_en_aon_i,
  input  logic wake_req_aon_i,
  output logic usb_oe_o,
  output logic usb_dp_o,
  output logic usb_dn_o,
  output logic busy_o,
  output logic done_o,
  output logic abort_o
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitIdle = 2'd1,
    StDriveK   = 2'd2,
    StRelease  = 2'd3
  } state_e;

  localparam logic [CntW-1:0] IdleLast   = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] ResumeLast = CntW'(ResumeCycles - 1);
  localparam logic [CntW-1:0] CntZero    = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    if (v == CntMax) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CntOne;
    end
  endfunction

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_dp_meta, r_dp_sync, r_dn_meta, r_dn_sync;
  logic            w_bus_j, w_qual_ok, w_abort_nxt, w_done_nxt, w_oe_nxt, w_busy_nxt;
  logic            w_tmo_hit;
  logic            r_oe, r_dp, r_dn, r_busy, r_done, r_abort;

  // Two-flop synchroniser for the asynchronous pin levels.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      r_dp_meta <= 1'b0;
      r_dp_sync <= 1'b0;
      r_dn_meta <= 1'b0;
      r_dn_sync <= 1'b0;
    end else begin
      r_dp_meta <= usb_dp_i;
      r_dp_sync <= r_dp_meta;
      r_dn_meta <= usb_dn_i;
      r_dn_sync <= r_dn_meta;
    end
  end

  assign w_bus_j   = r_dp_sync & ~r_dn_sync;
  assign w_qual_ok = suspended_aon_i & wake_en_aon_i;

`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] r_tmo, w_tmo_nxt;

  assign w_tmo_hit = (r_tmo == TmoLast);

  // Timeout timer runs on every WAIT_IDLE cycle regardless of bus state.
  always_comb begin
    w_tmo_nxt = CntZero;
    if (r_state == StWaitIdle) begin
      w_tmo_nxt = sat_inc(r_tmo);
    end else begin
      w_tmo_nxt = CntZero;
    end
  end

  // Timeout timer register.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      r_tmo <= CntZero;
    end else begin
      r_tmo <= w_tmo_nxt;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    case (r_state)
      StIdle: begin
        w_cnt_nxt = CntZero;
        if (wake_req_aon_i && w_qual_ok) begin
          w_state_nxt = StWaitIdle;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StWaitIdle: begin
        if (!w_qual_ok) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = CntZero;
          w_abort_nxt = 1'b1;
        end else if (w_bus_j && (r_cnt == IdleLast)) begin
          w_state_nxt = StDriveK;
          w_cnt_nxt   = CntZero;
        end else if (w_tmo_hit) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = CntZero;
          w_abort_nxt = 1'b1;
        end else if (w_bus_j) begin
          w_cnt_nxt = sat_inc(r_cnt);
        end else begin
          w_cnt_nxt = CntZero;
        end
      end
      // Once K starts it always runs to completion; qualifiers are not consulted.
      StDriveK: begin
        if (r_cnt == ResumeLast) begin
          w_state_nxt = StRelease;
          w_cnt_nxt   = CntZero;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      StRelease: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = CntZero;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = CntZero;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_comb begin
    w_oe_nxt   = (w_state_nxt == StDriveK);
    w_done_nxt = (w_state_nxt == StRelease);
    w_busy_nxt = (w_state_nxt == StWaitIdle) || (w_state_nxt == StDriveK);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      r_state <= StIdle;
      r_cnt   <= CntZero;
      r_oe    <= 1'b0;
      r_dp    <= 1'b0;
      r_dn    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_oe    <= w_oe_nxt;
      r_dp    <= 1'b0;
      r_dn    <= w_oe_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign usb_oe_o = r_oe;
  assign usb_dp_o = r_dp;
  assign usb_dn_o = r_dn;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign abort_o  = r_abort;

  usbdev_aon_resume_gen_chk #(
    .IdleCycles   (IdleCycles),
    .ResumeCycles (ResumeCycles),
    .TimeoutCycles(TimeoutCycles),
    .CntW         (CntW)
  ) u_chk (
    .clk_aon_i(clk_aon_i)
  );

endmodule

// File: tb/tb_usbdev_aon_resume_gen.sv
// Directed self-checking bench for usbdev_aon_resume_gen (default parameters).
module tb_usbdev_aon_resume_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp_i = 1'b1, dn_i = 1'b0;
  logic susp = 1'b1, en = 1'b1, req = 1'b0;
  logic oe, dp_o, dn_o, busy, done, abort;

  int n_checks = 0, n_pass = 0;
  int first_oe, last_oe, n_oe, n_done, done_at, n_abort, abort_at, bad_drive, n_busy, busy0, busy_at_pulse;

  usbdev_aon_resume_gen dut (
    .clk_aon_i(clk), .rst_aon_ni(rst_n), .usb_dp_i(dp_i), .usb_dn_i(dn_i),
    .suspended_aon_i(susp), .wake_en_aon_i(en), .wake_req_aon_i(req),
    .usb_oe_o(oe), .usb_dp_o(dp_o), .usb_dn_o(dn_o),
    .busy_o(busy), .done_o(done), .abort_o(abort)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Request at sample 0; gather statistics over n samples taken on the falling edge.
  task automatic run(input int n, input int se0_at, input int susp_at, input int en_at, input int req2_at);
    first_oe = -1; last_oe = -1; n_oe = 0; n_done = 0; done_at = -1; n_abort = 0; abort_at = -1;
    bad_drive = 0; n_busy = 0; busy0 = 0; busy_at_pulse = 0;
    for (int i = 0; i < n; i++) begin
      req = (i == 0) || (i == req2_at);
      @(posedge clk); @(negedge clk);
      if (i == 0) busy0 = busy;
      if (oe) begin
        if (first_oe < 0) first_oe = i;
        last_oe = i; n_oe++;
        if (dp_o !== 1'b0 || dn_o !== 1'b1) bad_drive++;
      end else if (dp_o !== 1'b0 || dn_o !== 1'b0) bad_drive++;
      if (done) begin n_done++; done_at = i; if (busy) busy_at_pulse++; end
      if (abort) begin n_abort++; abort_at = i; if (busy) busy_at_pulse++; end
      if (busy) n_busy++;
      if (se0_at >= 0 && i == se0_at) dp_i = 1'b0;
      if (se0_at >= 0 && i == se0_at + 3) dp_i = 1'b1;
      if (i == susp_at) susp = 1'b0;
      if (i == en_at) en = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    n_checks++; if ({oe, dp_o, dn_o} !== 3'b000) $display("FAIL reset_pins: got %b expected 000", {oe, dp_o, dn_o}); else n_pass++;
    n_checks++; if ({busy, done, abort} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {busy, done, abort}); else n_pass++;
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    run(1410, -1, -1, -1, -1);
    n_checks++; if (busy0 !== 1) $display("FAIL basic_busy_rise: got %0d expected 1", busy0); else n_pass++;
    n_checks++; if (first_oe !== 1000) $display("FAIL basic_k_start: got %0d expected 1000", first_oe); else n_pass++;
    n_checks++; if (n_oe !== 400) $display("FAIL basic_k_len: got %0d expected 400", n_oe); else n_pass++;
    n_checks++; if (last_oe !== 1399) $display("FAIL basic_k_end: got %0d expected 1399", last_oe); else n_pass++;
    n_checks++; if (bad_drive !== 0) $display("FAIL basic_drive_val: got %0d bad cycles expected 0", bad_drive); else n_pass++;
    n_checks++; if (n_done !== 1 || done_at !== 1400) $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 1400", n_done, done_at); else n_pass++;
    n_checks++; if (busy_at_pulse !== 0 || n_abort !== 0) $display("FAIL basic_exit: got busy_at_pulse %0d aborts %0d expected 0 0", busy_at_pulse, n_abort); else n_pass++;
    n_checks++; if (n_busy !== 1400 || busy !== 1'b0) $display("FAIL basic_busy_len: got %0d busy=%b expected 1400 0", n_busy, busy); else n_pass++;
  endtask

  task automatic test_glitch();
    run(2020, 599, -1, -1, -1);
    n_checks++; if (first_oe !== 1604) $display("FAIL glitch_k_start: got %0d expected 1604", first_oe); else n_pass++;
    n_checks++; if (n_oe !== 400 || bad_drive !== 0) $display("FAIL glitch_k_len: got %0d bad %0d expected 400 0", n_oe, bad_drive); else n_pass++;
    n_checks++; if (n_done !== 1 || done_at !== 2004) $display("FAIL glitch_done: got %0d at %0d expected 1 at 2004", n_done, done_at); else n_pass++;
  endtask

  task automatic test_unqualified();
    en = 1'b0;
    run(50, -1, -1, -1, -1);
    en = 1'b1;
    n_checks++; if (n_busy + n_oe + n_done + n_abort !== 0) $display("FAIL unqual_en: got busy %0d oe %0d done %0d abort %0d expected all 0", n_busy, n_oe, n_done, n_abort); else n_pass++;
    susp = 1'b0;
    run(50, -1, -1, -1, -1);
    susp = 1'b1;
    n_checks++; if (n_busy + n_oe + n_done + n_abort !== 0) $display("FAIL unqual_susp: got busy %0d oe %0d done %0d abort %0d expected all 0", n_busy, n_oe, n_done, n_abort); else n_pass++;
  endtask

  task automatic test_abort();
    run(520, -1, 499, -1, -1);
    susp = 1'b1;
    n_checks++; if (n_abort !== 1 || abort_at !== 500) $display("FAIL abort_pulse: got %0d at %0d expected 1 at 500", n_abort, abort_at); else n_pass++;
    n_checks++; if (n_oe !== 0 || n_done !== 0) $display("FAIL abort_no_k: got oe %0d done %0d expected 0 0", n_oe, n_done); else n_pass++;
    n_checks++; if (n_busy !== 500 || busy_at_pulse !== 0) $display("FAIL abort_busy: got %0d at_pulse %0d expected 500 0", n_busy, busy_at_pulse); else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_mid_drive();
    int extra_pulses;
    run(1100, -1, -1, -1, -1);
    n_checks++; if (n_oe !== 100) $display("FAIL rstk_before: got %0d expected 100", n_oe); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({oe, dn_o, busy} !== 3'b000) $display("FAIL rstk_immediate: got %b expected 000", {oe, dn_o, busy}); else n_pass++;
    extra_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      if (done || abort) extra_pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (done || abort || oe) extra_pulses++;
    end
    n_checks++; if (extra_pulses !== 0) $display("FAIL rstk_no_pulse: got %0d expected 0", extra_pulses); else n_pass++;
    run(1410, -1, -1, -1, -1);
    n_checks++; if (first_oe !== 1000 || n_oe !== 400 || n_done !== 1) $display("FAIL rstk_after: got start %0d len %0d done %0d expected 1000 400 1", first_oe, n_oe, n_done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run(1500, -1, -1, 1100, 1200);
    en = 1'b1;
    n_checks++; if (n_oe !== 400 || n_done !== 1 || n_abort !== 0) $display("FAIL b2b_full_k: got oe %0d done %0d abort %0d expected 400 1 0", n_oe, n_done, n_abort); else n_pass++;
    n_checks++; if (n_busy !== 1400) $display("FAIL b2b_no_queue: got %0d busy cycles expected 1400", n_busy); else n_pass++;
  endtask

  task automatic test_timeout();
    dp_i = 1'b0; dn_i = 1'b1;
    idle(3);
    run(4100, -1, -1, -1, -1);
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
    n_checks++; if (n_abort !== 1 || abort_at !== 4000) $display("FAIL timeout_abort: got %0d at %0d expected 1 at 4000", n_abort, abort_at); else n_pass++;
    n_checks++; if (n_oe !== 0 || busy !== 1'b0) $display("FAIL timeout_idle: got oe %0d busy %b expected 0 0", n_oe, busy); else n_pass++;
`else
    n_checks++; if (n_abort !== 0 || n_busy !== 4100) $display("FAIL notimeout_busy: got abort %0d busy %0d expected 0 4100", n_abort, n_busy); else n_pass++;
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({abort, busy} !== 2'b10) $display("FAIL notimeout_en_drop: got %b expected 10", {abort, busy}); else n_pass++;
`endif
    en = 1'b1; dp_i = 1'b1; dn_i = 1'b0;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_unqualified();
    test_abort();
    test_reset_mid_drive();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
